// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// running comparison decision.
package serial_cmp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DEC_EQ = 2'b00,
    DEC_LT = 2'b01,
    DEC_GT = 2'b10
  } dec_t;

endpackage

// File: rtl/serial_cmp_core.sv
// Next-decision logic for one accepted bit pair of a serial compare.
module serial_cmp_core
  import serial_cmp_pkg::*;
(
  input  dec_t dec_i,
  input  logic a,
  input  logic b,
  input  logic is_sign_bit,
  input  logic signed_en,
  input  logic lsb_first,
  output dec_t dec_o
);

  dec_t raw;

  always_comb begin
    raw = a ? DEC_GT : DEC_LT;
    // A set sign bit means a negative operand, so the sense flips there
    if (signed_en && is_sign_bit) begin
      raw = a ? DEC_LT : DEC_GT;
    end
    dec_o = dec_i;
    // MSB-first keeps the first difference; LSB-first lets later (higher) bits win
    if ((a != b) && (lsb_first || (dec_i == DEC_EQ))) begin
      dec_o = raw;
    end
  end

endmodule

// File: rtl/serial_comparator_n.sv
// Bit-serial comparator of two WIDTH-bit operands, signed or unsigned,
// MSB-first or LSB-first, with a registered lt/gt/eq result per frame.
module serial_comparator_n
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic a,
  input  logic b,
  input  logic signed_en,
  input  logic lsb_first,
  output logic busy,
  output logic done,
  output logic lt,
  output logic gt,
  output logic eq
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             lsb_q, lsb_d;
  logic             done_q, done_d;
  dec_t             dec_q, dec_d;
  dec_t             res_q, res_d;
  dec_t             dec_next;
  logic             is_sign_bit;

  // The sign bit is the first bit seen MSB-first and the last one LSB-first
  always_comb begin
    is_sign_bit = lsb_q ? (cnt_q == LAST_IDX) : (cnt_q == '0);
  end

  serial_cmp_core u_core (
    .dec_i       (dec_q),
    .a           (a),
    .b           (b),
    .is_sign_bit (is_sign_bit),
    .signed_en   (signed_q),
    .lsb_first   (lsb_q),
    .dec_o       (dec_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    lsb_d    = lsb_q;
    dec_d    = dec_q;
    res_d    = res_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          signed_d = signed_en;
          lsb_d    = lsb_first;
          dec_d    = DEC_EQ;
        end
      end
      ST_RUN: begin
        if (bit_valid) begin
          dec_d = dec_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            res_d   = dec_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      lsb_q    <= 1'b0;
      done_q   <= 1'b0;
      dec_q    <= DEC_EQ;
      res_q    <= DEC_EQ;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      lsb_q    <= lsb_d;
      done_q   <= done_d;
      dec_q    <= dec_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = done_q;
    lt   = (res_q == DEC_LT);
    gt   = (res_q == DEC_GT);
    eq   = (res_q == DEC_EQ);
  end

endmodule

// File: doc/serial_comparator_n.md
SERIAL_COMPARATOR_N -- requirements
Module: serial_comparator_n

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per compared word; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a new comparison frame; sampled only when not busy.
REQ-005 bit_valid  input  1  a and b carry a valid bit pair this cycle.
REQ-006 a  input  1  serial bit of operand A.
REQ-007 b  input  1  serial bit of operand B.
REQ-008 signed_en  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-009 lsb_first  input  1  1 = bits arrive LSB first, 0 = MSB first; sampled with start.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse: frame complete, results updated.
REQ-012 lt  output  1  A < B for the last completed frame.
REQ-013 gt  output  1  A > B for the last completed frame.
REQ-014 eq  output  1  A == B for the last completed frame.

Function
REQ-015 FSM states IDLE and RUN; IDLE->RUN on start=1; RUN->IDLE on acceptance of bit WIDTH.
REQ-016 Bits are accepted only in RUN with bit_valid=1; bit_valid in IDLE is ignored; the start cycle carries no data.
REQ-017 Bit counter clears on start, increments per accepted bit; width clog2(WIDTH+1).
REQ-018 signed_en and lsb_first are latched on start and held constant for the frame.
REQ-019 MSB-first: the first differing bit pair decides; later bits do not change the decision.
REQ-020 LSB-first: every differing bit pair overrides the previous decision; the last differing pair decides.
REQ-021 Signed mode: a differing pair at the sign bit (bit WIDTH-1) decides with inverted sense (a=1,b=0 gives lt).
REQ-022 All WIDTH bits are always consumed; no early termination.
REQ-023 done asserts for exactly one cycle, in the cycle after the last bit is accepted; lt/gt/eq update in that same cycle.
REQ-024 lt/gt/eq hold the last frame's result during a new frame until its done; exactly one of lt, gt, eq is 1 at all times.
REQ-025 busy=1 from the cycle after start through the cycle the last bit is accepted; busy=0 when done=1.
REQ-026 start while busy is ignored; start coincident with done is accepted and begins a new frame.
REQ-027 Gaps in bit_valid stall the frame indefinitely with no timeout; latency = WIDTH accepted bits + 1 cycle.

Reset
REQ-028 reset has priority over all other inputs and aborts any frame in progress.
REQ-029 Reset values: state IDLE, counter 0, busy=0, done=0, lt=0, gt=0, eq=1, latched modes 0.
REQ-030 The first start after reset release is accepted normally.

Structure
REQ-031 Package serial_cmp_pkg holds the FSM state typedef and the 2-bit decision encoding (EQ, LT, GT).
REQ-032 One sub-module, serial_cmp_core: combinational next-decision logic from (decision, a, b, is_sign_bit, signed_en, lsb_first).
REQ-033 The top holds the FSM, counter, mode latches and output registers; no other hierarchy.

Verification (WIDTH=8, back-to-back bit_valid unless stated)
REQ-034 Unsigned, MSB-first, A=0x5A, B=0x5B; start at cycle 0, bits at cycles 1-8 -> done at cycle 9, lt=1, busy low at cycle 9.
REQ-035 Signed, MSB-first, A=0x80, B=0x01 -> lt=1; the same operands unsigned -> gt=1.
REQ-036 Unsigned, LSB-first, A=0x01, B=0x80 -> lt=1 (the higher-order difference overrides the bit-0 difference).
REQ-037 A=B=0x3C with bit_valid low for 3 cycles after bit 4 -> done at cycle 12, eq=1; prior result held until then.
REQ-038 reset asserted after 4 bits accepted -> next cycle busy=0, eq=1, lt=gt=0, no done; a following full frame with A=0xFF, B=0x00 -> gt=1.
REQ-039 start pulsed mid-frame -> ignored; start coincident with done -> new frame runs, busy=1 in the next cycle.
